pcpu_mem_server: RTL and testbench
==================================

# pcpu_mem_server

Memory responder for the pipelined CPU. Serves the CPU's instruction-fetch port and data-memory port from two on-chip word RAMs, and drives the CPU's `start` and `enable` controls. A host command port loads both memories before a run, starts and halts the CPU, and, when configured, streams data memory back afterwards.

## Interface
- `AW`, 8: address width of both memories.
- `DW`, 16: word width.
- `clock`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `i_addr`  in  AW  CPU instruction address.
- `i_datain`  out  DW  instruction word to CPU.
- `d_addr`  in  AW  CPU data address.
- `d_dataout`  in  DW  CPU store data.
- `d_we`  in  1  CPU store strobe.
- `d_datain`  out  DW  load data to CPU.
- `cpu_start`  out  1  one-cycle start pulse to CPU.
- `cpu_enable`  out  1  CPU run enable.
- `host_cmd_valid` / `host_cmd_ready`  in/out  1  command handshake.
- `host_cmd`  in  2  00 load IMEM, 01 load DMEM, 10 run, 11 dump.
- `host_len`  in  AW  word count minus 1; sampled when the command is accepted.
- `host_wdata_valid` / `host_wdata_ready`  in/out  1  load-data handshake.
- `host_wdata`  in  DW  load word.
- `host_rdata_valid` / `host_rdata_ready`  out/in  1  dump-data handshake.
- `host_rdata`  out  DW  dump word.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD_I, LOAD_D, RUN, DUMP.
- `host_cmd_ready` is 1 in IDLE and RUN and 0 elsewhere. A command is accepted on an edge where `host_cmd_valid` and `host_cmd_ready` are both 1.
- Accepted in IDLE:
  - 00 goes to LOAD_I; 01 goes to LOAD_D.
  - 10 goes to RUN.
  - 11 goes to DUMP.
  - Each accepted command clears `ptr` to 0 and latches `len` from `host_len`.
- LOAD_x:
  - `host_wdata_ready` is 1.
  - Each wdata handshake writes `mem[ptr] <= host_wdata`, then increments `ptr`.
  - The handshake made with `ptr==len` returns the FSM to IDLE.
- RUN:
  - `cpu_enable` is 1.
  - `cpu_start` is 1 for exactly the first cycle in RUN.
  - A CPU store with `d_we` high writes `dmem[d_addr] <= d_dataout`.
  - Any command accepted in RUN halts the CPU and returns to IDLE. The command code is discarded.
- Read paths are combinational and are active in every state: `i_datain = imem[i_addr]`, `d_datain = dmem[d_addr]`.
- `d_we` is ignored outside RUN.
- `host_wdata` arriving outside LOAD_x is not accepted, because `host_wdata_ready` is 0.
- Address arithmetic:
  - `ptr` is AW bits wide and wraps modulo 2^AW.
  - With `len` = 2^AW−1, all words are transferred and `ptr` ends at 0.

## Timing
- Reset values:
  - State IDLE; `ptr`=0; `len`=0.
  - `cpu_start`=0, `cpu_enable`=0, `busy`=0.
  - `host_wdata_ready`=0, `host_rdata_valid`=0, `host_rdata`=0.
  - `host_cmd_ready`=1.
  - RAM contents are not reset.
- Reset mid-operation: the FSM returns to IDLE. Words already written stay in memory. The CPU is disabled on the next cycle.
- A load write is visible on the read ports in the cycle after its handshake edge.
- DUMP:
  - Command accepted at edge t.
  - `host_rdata_valid` goes to 1 after edge t+1, carrying `dmem[0]`.
  - The data is registered and held stable while `host_rdata_ready` is 0.
  - After a handshake, the next word is presented on the following cycle with no bubble.
  - After the handshake of word `len`, `host_rdata_valid` drops and the FSM enters IDLE at the same edge.
- RUN entry: `cpu_start` and `cpu_enable` rise one cycle after the run command is accepted.
- RUN exit: `cpu_enable` falls one cycle after the halting command is accepted.

## Configuration
- `MEMSRV_DUMP_EN` defined: DUMP state and the rdata path are built as described above.
- `MEMSRV_DUMP_EN` undefined:
  - Command 11 is accepted in IDLE as a no-op; the FSM stays in IDLE.
  - `host_rdata_valid` and `host_rdata` are tied to 0.
  - No DUMP state logic is built.

## Structure
- Package `pcpu_mem_pkg` holds:
  - the state enum;
  - command code constants (CMD_LOAD_I, CMD_LOAD_D, CMD_RUN, CMD_DUMP);
  - default AW/DW constants.
- Sub-module `pcpu_ram`:
  - AW×DW array;
  - one synchronous write port;
  - two asynchronous read ports: CPU read and dump read.
  - Instantiated once for IMEM and once for DMEM.
- FSM, `ptr`/`len` counters and handshakes live in the top module.

## Test plan
- Load IMEM with `len`=3, words 0x1111…0x4444, `host_wdata_valid` gapped every other cycle. Then `i_addr`=2 must give `i_datain`=0x3333, and the FSM must be in IDLE after the 4th handshake.
- Issue run: `cpu_start` must be high for one cycle, then `cpu_enable` held at 1. A CPU store `d_addr`=0x10, 0xBEEF must give `d_datain`=0xBEEF on the next cycle with `d_addr`=0x10. Any command must then drop `cpu_enable`.
- `d_we`=1 with `d_addr`=0x10 and data 0x0000 while in IDLE: `dmem[0x10]` must remain 0xBEEF.
- Dump with `len`=1 and `host_rdata_ready` low for 3 cycles: `host_rdata` must hold `dmem[0]` stable. Then two handshakes must return `dmem[0]` and `dmem[1]`, followed by IDLE. With the macro undefined, the FSM must stay in IDLE and `host_rdata_valid` must stay 0.
- Load DMEM with `len`=255 (256 words): `ptr` must wrap to 0, and all 256 addresses must read back correctly.
- Assert `reset` after 2 of 4 words in LOAD_I: outputs must take their reset values at the next edge, and words 0–1 must be retained.

Source files
------------

// File: rtl/pcpu_mem_pkg.sv
// Shared types and constants for the pipelined-CPU memory server.
// Command codes, FSM states and default memory geometry.
package pcpu_mem_pkg;

    localparam int MEMSRV_AW = 8;
    localparam int MEMSRV_DW = 16;

    localparam logic [1:0] CMD_LOAD_I = 2'b00;
    localparam logic [1:0] CMD_LOAD_D = 2'b01;
    localparam logic [1:0] CMD_RUN    = 2'b10;
    localparam logic [1:0] CMD_DUMP   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_D,
        S_RUN,
        S_DUMP
    } state_e;

endpackage

// File: rtl/pcpu_mem_server_if.sv
// Host-side command / load-data / dump-data bundle of the memory server.
// The host drives through master; the server connects through slave.
interface pcpu_mem_server_if #(
    parameter int AW = pcpu_mem_pkg::MEMSRV_AW,
    parameter int DW = pcpu_mem_pkg::MEMSRV_DW
) ();

    logic          host_cmd_valid;
    logic          host_cmd_ready;
    logic [1:0]    host_cmd;
    logic [AW-1:0] host_len;
    logic          host_wdata_valid;
    logic          host_wdata_ready;
    logic [DW-1:0] host_wdata;
    logic          host_rdata_valid;
    logic          host_rdata_ready;
    logic [DW-1:0] host_rdata;

    modport master (
        output host_cmd_valid, host_cmd, host_len,
        output host_wdata_valid, host_wdata,
        output host_rdata_ready,
        input  host_cmd_ready, host_wdata_ready,
        input  host_rdata_valid, host_rdata
    );

    modport slave (
        input  host_cmd_valid, host_cmd, host_len,
        input  host_wdata_valid, host_wdata,
        input  host_rdata_ready,
        output host_cmd_ready, host_wdata_ready,
        output host_rdata_valid, host_rdata
    );

endinterface

// File: rtl/pcpu_ram.sv
// Word RAM: one synchronous write port, two asynchronous read ports.
// Contents are deliberately not reset.
module pcpu_ram
    import pcpu_mem_pkg::*;
#(
    parameter int AW = MEMSRV_AW,
    parameter int DW = MEMSRV_DW
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/pcpu_mem_server.sv
// Memory responder for the pipelined CPU: IMEM/DMEM, host load/run/dump.
// Define MEMSRV_DUMP_EN to build the DMEM dump (read-back) path.
module pcpu_mem_server
    import pcpu_mem_pkg::*;
#(
    parameter int AW = MEMSRV_AW,
    parameter int DW = MEMSRV_DW
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_datain,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_dataout,
    input  logic            d_we,
    output logic [DW-1:0]   d_datain,
    output logic            cpu_start,
    output logic            cpu_enable,
    output logic            busy,
    pcpu_mem_server_if.slave host
);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] len_q, len_d;
    logic          start_q, start_d;

    logic          imem_we, dmem_we;
    logic [AW-1:0] dmem_waddr;
    logic [DW-1:0] dmem_wdata;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_rdata;
    logic [DW-1:0] imem_rd_b_unused;

`ifdef MEMSRV_DUMP_EN
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    // Read one word ahead so the next word is ready right after a handshake.
    assign dump_addr = rvalid_q ? ptr_q + 1'b1 : ptr_q;
`else
    logic unused_dump;

    assign dump_addr   = '0;
    assign unused_dump = ^dump_rdata ^ host.host_rdata_ready;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        start_d    = 1'b0;
        imem_we    = 1'b0;
        dmem_we    = 1'b0;
        dmem_waddr = ptr_q;
        dmem_wdata = host.host_wdata;
`ifdef MEMSRV_DUMP_EN
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (host.host_cmd_valid) begin
                    ptr_d = '0;
                    len_d = host.host_len;
                    unique case (host.host_cmd)
                        CMD_LOAD_I: state_d = S_LOAD_I;
                        CMD_LOAD_D: state_d = S_LOAD_D;
                        CMD_RUN: begin
                            state_d = S_RUN;
                            start_d = 1'b1;
                        end
`ifdef MEMSRV_DUMP_EN
                        CMD_DUMP:   state_d = S_DUMP;
`else
                        CMD_DUMP:   state_d = S_IDLE;
`endif
                    endcase
                end
            end
            S_LOAD_I, S_LOAD_D: begin
                if (host.host_wdata_valid) begin
                    imem_we = (state_q == S_LOAD_I) && !reset;
                    dmem_we = (state_q == S_LOAD_D) && !reset;
                    ptr_d   = ptr_q + 1'b1;
                    if (ptr_q == len_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                dmem_we    = d_we && !reset;
                dmem_waddr = d_addr;
                dmem_wdata = d_dataout;
                if (host.host_cmd_valid) begin
                    state_d = S_IDLE;
                end
            end
`ifdef MEMSRV_DUMP_EN
            S_DUMP: begin
                if (!rvalid_q) begin
                    rvalid_d = 1'b1;
                    rdata_d  = dump_rdata;
                end else if (host.host_rdata_ready) begin
                    if (ptr_q == len_q) begin
                        rvalid_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        rdata_d = dump_rdata;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            start_q <= start_d;
        end
    end

`ifdef MEMSRV_DUMP_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign host.host_rdata_valid = rvalid_q;
    assign host.host_rdata       = rdata_q;
`else
    assign host.host_rdata_valid = 1'b0;
    assign host.host_rdata       = '0;
`endif

    assign host.host_cmd_ready   = (state_q == S_IDLE) || (state_q == S_RUN);
    assign host.host_wdata_ready = (state_q == S_LOAD_I) || (state_q == S_LOAD_D);
    assign cpu_start             = start_q;
    assign cpu_enable            = (state_q == S_RUN);
    assign busy                  = (state_q != S_IDLE);

    pcpu_ram #(.AW(AW), .DW(DW)) u_imem (
        .clk_i     (clock),
        .we_i      (imem_we),
        .waddr_i   (ptr_q),
        .wdata_i   (host.host_wdata),
        .raddr_a_i (i_addr),
        .rdata_a_o (i_datain),
        .raddr_b_i ({AW{1'b0}}),
        .rdata_b_o (imem_rd_b_unused)
    );

    pcpu_ram #(.AW(AW), .DW(DW)) u_dmem (
        .clk_i     (clock),
        .we_i      (dmem_we),
        .waddr_i   (dmem_waddr),
        .wdata_i   (dmem_wdata),
        .raddr_a_i (d_addr),
        .rdata_a_o (d_datain),
        .raddr_b_i (dump_addr),
        .rdata_b_o (dump_rdata)
    );

endmodule

// File: tb/tb_pcpu_mem_server.sv
// Directed bench for pcpu_mem_server: load, run, idle-store, dump, reset.
// Dump checks follow whichever MEMSRV_DUMP_EN build is compiled.
module tb_pcpu_mem_server;
    import pcpu_mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  i_addr = '0;
    logic [15:0] i_datain;
    logic [7:0]  d_addr = '0;
    logic [15:0] d_dataout = '0;
    logic        d_we = 1'b0;
    logic [15:0] d_datain;
    logic        cpu_start;
    logic        cpu_enable;
    logic        busy;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    pcpu_mem_server_if #(.AW(8), .DW(16)) bus ();

    pcpu_mem_server #(.AW(8), .DW(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .i_addr     (i_addr),
        .i_datain   (i_datain),
        .d_addr     (d_addr),
        .d_dataout  (d_dataout),
        .d_we       (d_we),
        .d_datain   (d_datain),
        .cpu_start  (cpu_start),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .host       (bus)
    );

    function automatic logic [15:0] dval(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {b, ~b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c, input logic [7:0] l);
        int t = 0;
        bus.host_cmd_valid = 1'b1;
        bus.host_cmd       = c;
        bus.host_len       = l;
        #1;
        while (!bus.host_cmd_ready && t < 20) begin
            tick();
            t++;
        end
        if (t == 20) chk("cmd_timeout", 0, 1);
        tick();
        bus.host_cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d);
        int t = 0;
        bus.host_wdata_valid = 1'b1;
        bus.host_wdata       = d;
        #1;
        while (!bus.host_wdata_ready && t < 20) begin
            tick();
            t++;
        end
        if (t == 20) chk("wdata_timeout", 0, 1);
        tick();
        bus.host_wdata_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] iw [4];
        int          bad;
        iw[0] = 16'h1111; iw[1] = 16'h2222;
        iw[2] = 16'h3333; iw[3] = 16'h4444;
        bus.host_cmd_valid   = 1'b0;
        bus.host_cmd         = '0;
        bus.host_len         = '0;
        bus.host_wdata_valid = 1'b0;
        bus.host_wdata       = '0;
        bus.host_rdata_ready = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_busy",   busy, 0);
        chk("rst_cmdrdy", bus.host_cmd_ready, 1);
        chk("rst_wdrdy",  bus.host_wdata_ready, 0);
        chk("rst_rvalid", bus.host_rdata_valid, 0);
        chk("rst_rdata",  bus.host_rdata, 0);
        chk("rst_start",  cpu_start, 0);
        chk("rst_enable", cpu_enable, 0);
        reset = 1'b0;
        tick();

        // IMEM load, gapped
        send_cmd(CMD_LOAD_I, 8'd3);
        chk("ldi_busy",   busy, 1);
        chk("ldi_wdrdy",  bus.host_wdata_ready, 1);
        chk("ldi_cmdrdy", bus.host_cmd_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            send_word(iw[i]);
            if (i == 2) chk("ldi_busy3", busy, 1);
        end
        chk("ldi_idle", busy, 0);
        i_addr = 8'd2; #1;
        chk("ldi_rd2", i_datain, 16'h3333);
        i_addr = 8'd0; #1;
        chk("ldi_rd0", i_datain, 16'h1111);
        i_addr = 8'd3; #1;
        chk("ldi_rd3", i_datain, 16'h4444);

        // DMEM load, full 256 words
        send_cmd(CMD_LOAD_D, 8'd255);
        for (int k = 0; k < 256; k++) begin
            send_word(dval(k));
            if (k == 254) chk("ldd_busy255", busy, 1);
        end
        chk("ldd_idle", busy, 0);
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            d_addr = 8'(k); #1;
            if (d_datain !== dval(k)) bad++;
        end
        chk("ldd_readback_errs", bad, 0);

        // Run, CPU store, halt
        d_addr = 8'h10; #1;
        chk("run_pre", d_datain, 16'h10EF);
        send_cmd(CMD_RUN, 8'd0);
        chk("run_start",  cpu_start, 1);
        chk("run_enable", cpu_enable, 1);
        chk("run_cmdrdy", bus.host_cmd_ready, 1);
        tick();
        chk("run_start2", cpu_start, 0);
        chk("run_enable2", cpu_enable, 1);
        d_dataout = 16'hBEEF;
        d_we      = 1'b1;
        tick();
        d_we = 1'b0;
        #1;
        chk("run_store", d_datain, 16'hBEEF);
        chk("run_enable3", cpu_enable, 1);
        send_cmd(CMD_DUMP, 8'd5);
        chk("halt_enable", cpu_enable, 0);
        chk("halt_busy",   busy, 0);

        // Store strobe ignored while idle
        d_dataout = 16'h0000;
        d_we      = 1'b1;
        tick();
        d_we = 1'b0;
        #1;
        chk("idle_store", d_datain, 16'hBEEF);

        // Dump / no-op dump
        send_cmd(CMD_DUMP, 8'd1);
`ifdef MEMSRV_DUMP_EN
        chk("dmp_busy",    busy, 1);
        chk("dmp_vld0",    bus.host_rdata_valid, 0);
        tick();
        chk("dmp_vld1",    bus.host_rdata_valid, 1);
        chk("dmp_w0",      bus.host_rdata, 16'h00FF);
        tick();
        tick();
        chk("dmp_hold",    bus.host_rdata, 16'h00FF);
        chk("dmp_holdv",   bus.host_rdata_valid, 1);
        bus.host_rdata_ready = 1'b1;
        tick();
        chk("dmp_w1",      bus.host_rdata, 16'h01FE);
        chk("dmp_vld2",    bus.host_rdata_valid, 1);
        tick();
        bus.host_rdata_ready = 1'b0;
        chk("dmp_vlddrop", bus.host_rdata_valid, 0);
        chk("dmp_idle",    busy, 0);
`else
        chk("nodmp_busy",  busy, 0);
        chk("nodmp_vld",   bus.host_rdata_valid, 0);
        bus.host_rdata_ready = 1'b1;
        repeat (3) tick();
        bus.host_rdata_ready = 1'b0;
        chk("nodmp_busy2", busy, 0);
        chk("nodmp_vld2",  bus.host_rdata_valid, 0);
        chk("nodmp_rdata", bus.host_rdata, 0);
`endif

        // Reset in the middle of an IMEM load
        send_cmd(CMD_LOAD_I, 8'd3);
        send_word(16'hAAAA);
        send_word(16'hBBBB);
        chk("mrst_busy_pre", busy, 1);
        reset = 1'b1;
        tick();
        chk("mrst_busy",   busy, 0);
        chk("mrst_wdrdy",  bus.host_wdata_ready, 0);
        chk("mrst_cmdrdy", bus.host_cmd_ready, 1);
        chk("mrst_enable", cpu_enable, 0);
        chk("mrst_start",  cpu_start, 0);
        reset = 1'b0;
        tick();
        i_addr = 8'd0; #1;
        chk("mrst_w0", i_datain, 16'hAAAA);
        i_addr = 8'd1; #1;
        chk("mrst_w1", i_datain, 16'hBBBB);
        i_addr = 8'd2; #1;
        chk("mrst_w2", i_datain, 16'h3333);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
